// File: rtl/acc_control_fsm_if.sv
// Control bundle between the accumulator control FSM (master) and the datapath (slave).
// The FSM consumes opcode, zero and ext_valid, and drives every strobe and select.
interface acc_control_fsm_if #(
   parameter int OPCODE_WIDTH = 5,
   parameter int STATE_WIDTH  = 4
);
   logic [OPCODE_WIDTH-1:0] opcode;
   logic                    zero;
   logic                    ext_valid;
   logic                    ir_load;
   logic                    pc_inc;
   logic                    pc_load;
   logic                    dmem_wr;
   logic                    sel_B;
   logic                    sel_imm;
   logic [1:0]              alu_op;
   logic                    acc_load;
   logic                    out_load;
   logic                    ext_ack;
   logic                    halted;
   logic [STATE_WIDTH-1:0]  state_out;

   modport master (
      input  opcode, zero, ext_valid,
      output ir_load, pc_inc, pc_load, dmem_wr, sel_B, sel_imm, alu_op,
             acc_load, out_load, ext_ack, halted, state_out
   );

   modport slave (
      output opcode, zero, ext_valid,
      input  ir_load, pc_inc, pc_load, dmem_wr, sel_B, sel_imm, alu_op,
             acc_load, out_load, ext_ack, halted, state_out
   );
endinterface

// File: rtl/acc_control_fsm.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit accumulator datapath.
// Moore outputs are decoded from state plus the opcode latched in DECODE.
module acc_control_fsm #(
   parameter int OPCODE_WIDTH = 5,
   parameter int STATE_WIDTH  = 4
) (
   input  logic            clk,
   input  logic            reset,
   acc_control_fsm_if.master bus
);
   localparam logic [STATE_WIDTH-1:0] S_FETCH   = STATE_WIDTH'(0);
   localparam logic [STATE_WIDTH-1:0] S_DECODE  = STATE_WIDTH'(1);
   localparam logic [STATE_WIDTH-1:0] S_MEM_RD  = STATE_WIDTH'(2);
   localparam logic [STATE_WIDTH-1:0] S_EXEC    = STATE_WIDTH'(3);
   localparam logic [STATE_WIDTH-1:0] S_STORE   = STATE_WIDTH'(4);
   localparam logic [STATE_WIDTH-1:0] S_WAIT_IN = STATE_WIDTH'(5);
   localparam logic [STATE_WIDTH-1:0] S_OUTPUT  = STATE_WIDTH'(6);
   localparam logic [STATE_WIDTH-1:0] S_JUMP    = STATE_WIDTH'(7);
   localparam logic [STATE_WIDTH-1:0] S_HALT    = STATE_WIDTH'(8);

   localparam logic [OPCODE_WIDTH-1:0] OP_HLT  = OPCODE_WIDTH'(0);
   localparam logic [OPCODE_WIDTH-1:0] OP_STO  = OPCODE_WIDTH'(1);
   localparam logic [OPCODE_WIDTH-1:0] OP_LD   = OPCODE_WIDTH'(2);
   localparam logic [OPCODE_WIDTH-1:0] OP_LDI  = OPCODE_WIDTH'(3);
   localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(4);
   localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(5);
   localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = OPCODE_WIDTH'(6);
   localparam logic [OPCODE_WIDTH-1:0] OP_SUBI = OPCODE_WIDTH'(7);
   localparam logic [OPCODE_WIDTH-1:0] OP_IN   = OPCODE_WIDTH'(8);
   localparam logic [OPCODE_WIDTH-1:0] OP_OUT  = OPCODE_WIDTH'(9);
   localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = OPCODE_WIDTH'(10);
   localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(11);

   logic [STATE_WIDTH-1:0]  state_q, state_d;
   logic [OPCODE_WIDTH-1:0] opc_q, opc_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         opc_q   <= '0;
      end else begin
         state_q <= state_d;
         opc_q   <= opc_d;
      end
   end

   // IR is valid from DECODE onward; hold its opcode for the execute-side states.
   assign opc_d = (state_q == S_DECODE) ? bus.opcode : opc_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            case (bus.opcode)
               OP_HLT:                 state_d = S_HALT;
               OP_LD, OP_ADD, OP_SUB:  state_d = S_MEM_RD;
               OP_LDI, OP_ADDI, OP_SUBI: state_d = S_EXEC;
               OP_STO:                 state_d = S_STORE;
               OP_IN:                  state_d = S_WAIT_IN;
               OP_OUT:                 state_d = S_OUTPUT;
               OP_JMP:                 state_d = S_JUMP;
               OP_BEQ:                 state_d = bus.zero ? S_JUMP : S_FETCH;
               default:                state_d = S_FETCH;
            endcase
         end
         S_MEM_RD:  state_d = S_EXEC;
         S_EXEC:    state_d = S_FETCH;
         S_STORE:   state_d = S_FETCH;
         S_WAIT_IN: state_d = bus.ext_valid ? S_FETCH : S_WAIT_IN;
         S_OUTPUT:  state_d = S_FETCH;
         S_JUMP:    state_d = S_FETCH;
         S_HALT:    state_d = S_HALT;
         default:   state_d = S_FETCH;
      endcase
   end

   // Every strobe is forced low while reset is high so an abandoned instruction has no side effect.
   always_comb begin
      bus.ir_load  = 1'b0;
      bus.pc_inc   = 1'b0;
      bus.pc_load  = 1'b0;
      bus.dmem_wr  = 1'b0;
      bus.sel_B    = 1'b0;
      bus.sel_imm  = 1'b0;
      bus.alu_op   = 2'b00;
      bus.acc_load = 1'b0;
      bus.out_load = 1'b0;
      bus.ext_ack  = 1'b0;
      bus.halted   = 1'b0;
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               bus.ir_load = 1'b1;
               bus.pc_inc  = 1'b1;
            end
            S_EXEC: begin
               bus.acc_load = 1'b1;
               bus.sel_imm  = (opc_q == OP_LDI) || (opc_q == OP_ADDI) || (opc_q == OP_SUBI);
               case (opc_q)
                  OP_ADD, OP_ADDI: bus.alu_op = 2'b01;
                  OP_SUB, OP_SUBI: bus.alu_op = 2'b10;
                  default:         bus.alu_op = 2'b00;
               endcase
            end
            S_STORE: bus.dmem_wr = 1'b1;
            S_WAIT_IN: begin
               bus.sel_B    = 1'b1;
               bus.acc_load = bus.ext_valid;
               bus.ext_ack  = bus.ext_valid;
            end
            S_OUTPUT: bus.out_load = 1'b1;
            S_JUMP:   bus.pc_load  = 1'b1;
            S_HALT:   bus.halted   = 1'b1;
            default: ;
         endcase
      end
   end

   assign bus.state_out = reset ? '0 : state_q;
endmodule

// File: tb/tb_acc_control_fsm.sv
// Directed bench for acc_control_fsm: walks each instruction class cycle by cycle
// and compares state_out and the packed output strobes against hand-derived values.
module tb_acc_control_fsm;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_bad;
   int   ack_cnt;

   acc_control_fsm_if #(.OPCODE_WIDTH(5), .STATE_WIDTH(4)) bus ();

   acc_control_fsm #(.OPCODE_WIDTH(5), .STATE_WIDTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {ir_load, pc_inc, pc_load, dmem_wr, sel_B, sel_imm, alu_op[1:0], acc_load, out_load, ext_ack, halted}
   logic [11:0] outs;
   assign outs = {bus.ir_load, bus.pc_inc, bus.pc_load, bus.dmem_wr, bus.sel_B, bus.sel_imm,
                  bus.alu_op, bus.acc_load, bus.out_load, bus.ext_ack, bus.halted};

   localparam logic [11:0] O_NONE  = 12'h000;
   localparam logic [11:0] O_FETCH = 12'hC00;
   localparam logic [11:0] O_LDI   = 12'h048;
   localparam logic [11:0] O_ADD   = 12'h018;
   localparam logic [11:0] O_SUBI  = 12'h068;
   localparam logic [11:0] O_WAIT  = 12'h080;
   localparam logic [11:0] O_INACK = 12'h08A;
   localparam logic [11:0] O_STO   = 12'h100;
   localparam logic [11:0] O_OUT   = 12'h004;
   localparam logic [11:0] O_JUMP  = 12'h200;
   localparam logic [11:0] O_HALT  = 12'h001;

   always @(posedge clk) if (bus.ext_ack) ack_cnt <= ack_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Check the current cycle (sampled 1ns after the falling edge), then advance to the next falling edge.
   task automatic cyc(input string tag, input int st, input logic [11:0] o);
      #1;
      chk({tag, "_st"}, 32'(bus.state_out), 32'(st));
      chk({tag, "_o"}, 32'(outs), 32'(o));
      $display("cycle %s: state=%0d outs=0x%03h", tag, bus.state_out, outs);
      @(negedge clk);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      ack_cnt = 0;
      reset = 1'b1;
      bus.opcode = 5'd0;
      bus.zero = 1'b0;
      bus.ext_valid = 1'b0;
      @(negedge clk);
      cyc("rst0", 0, O_NONE);
      cyc("rst1", 0, O_NONE);
      reset = 1'b0;

      bus.opcode = 5'b00011;
      cyc("ldi_f", 0, O_FETCH);
      cyc("ldi_d", 1, O_NONE);
      cyc("ldi_x", 3, O_LDI);

      bus.opcode = 5'b00100;
      cyc("add_f", 0, O_FETCH);
      cyc("add_d", 1, O_NONE);
      cyc("add_m", 2, O_NONE);
      cyc("add_x", 3, O_ADD);

      bus.opcode = 5'b00111;
      cyc("subi_f", 0, O_FETCH);
      cyc("subi_d", 1, O_NONE);
      cyc("subi_x", 3, O_SUBI);

      bus.opcode = 5'b00001;
      cyc("sto_f", 0, O_FETCH);
      cyc("sto_d", 1, O_NONE);
      cyc("sto_s", 4, O_STO);

      bus.opcode = 5'b01001;
      cyc("out_f", 0, O_FETCH);
      cyc("out_d", 1, O_NONE);
      cyc("out_o", 6, O_OUT);

      bus.opcode = 5'b01000;
      cyc("in_f", 0, O_FETCH);
      cyc("in_d", 1, O_NONE);
      for (int i = 0; i < 3; i++) cyc("in_w", 5, O_WAIT);
      bus.ext_valid = 1'b1;
      cyc("in_ack", 5, O_INACK);
      bus.ext_valid = 1'b0;
      chk("in_ackcnt", 32'(ack_cnt), 32'd1);

      bus.opcode = 5'b01011;
      bus.zero = 1'b1;
      cyc("beq1_f", 0, O_FETCH);
      cyc("beq1_d", 1, O_NONE);
      cyc("beq1_j", 7, O_JUMP);
      bus.zero = 1'b0;
      cyc("beq0_f", 0, O_FETCH);
      cyc("beq0_d", 1, O_NONE);

      bus.opcode = 5'b11111;
      cyc("nop_f", 0, O_FETCH);
      cyc("nop_d", 1, O_NONE);

      bus.opcode = 5'b01000;
      cyc("rin_f", 0, O_FETCH);
      cyc("rin_d", 1, O_NONE);
      cyc("rin_w", 5, O_WAIT);
      bus.ext_valid = 1'b1;
      reset = 1'b1;
      cyc("rin_rst", 0, O_NONE);
      reset = 1'b0;
      bus.ext_valid = 1'b0;
      chk("rin_ackcnt", 32'(ack_cnt), 32'd1);
      cyc("rin_after", 0, O_FETCH);

      bus.opcode = 5'b00000;
      cyc("hlt_d", 1, O_NONE);
      for (int i = 0; i < 20; i++) begin
         bus.ext_valid = i[0];
         cyc("hlt_h", 8, O_HALT);
      end
      bus.ext_valid = 1'b0;
      chk("hlt_ackcnt", 32'(ack_cnt), 32'd1);
      reset = 1'b1;
      cyc("hlt_rst", 0, O_NONE);
      reset = 1'b0;
      cyc("hlt_after", 0, O_FETCH);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
